rv32i_exec_mem: RTL and testbench
=================================

Name: rv32i_exec_mem

Overview:
- Execute/memory slice of the rv32i single-cycle core.
- Combines three parts: the main control decoder (`control`), the ALU (`alu`), and the 32-bit data memory (`bram32`, with an external init/debug port).
- Fetch, register file and sign extension sit outside this block. It consumes decoded instruction fields, rs1/rs2 and the extended immediate.
- It produces control strobes, the ALU result, the zero flag and load data.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 10, byte-address bits used by data memory.
- DEPTH, 256, memory words (2^ADDR_WIDTH/4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- rs1  in  32  register operand A.
- rs2  in  32  register operand B; also store data.
- immediate  in  32  sign-extended immediate.
- init_done  in  1  0 = external port owns memory writes; 1 = datapath owns them.
- ext_w_addr  in  10  external write byte address.
- ext_w_dat  in  32  external write data.
- ext_w_enb  in  1  external write enable.
- debug_addr  in  10  debug read byte address.
- debug_data  out  32  combinational memory read at debug_addr.
- branch  out  1  PC-select (take immediate target).
- imm_src  out  3  immediate format to sign extender.
- mem_read, mem_write, reg_write, alu_src, mem_2_reg  out  1 each  control strobes.
- alu_ctrl  out  4  ALU operation.
- wrt_back_src  out  2  write-back mux select.
- alu_results  out  32  ALU result; also memory address.
- alu_zero  out  1  alu_results == 0.
- mem_rdata  out  32  load data.

Behaviour:
- **Control decoder** (combinational). While rst is low, all control outputs are 0. Unknown opcode also drives all control outputs to 0.
  - R (0110011): reg_write=1, alu_src=0, wrt_back_src=ALU. Operation from func3, with func7[5] selecting SUB vs ADD and SRA vs SRL.
  - I-ALU (0010011): alu_src=1, imm_src=I. Same operation mapping except ADD is never SUB.
  - LOAD (0000011): ADD, alu_src=1, mem_read=1, mem_2_reg=1, wrt_back_src=MEM, reg_write=1.
  - STORE (0100011): ADD, alu_src=1, imm_src=S, mem_write=1, reg_write=0.
  - BRANCH (1100011): imm_src=B, alu_src=0.
    - beq/bne use SUB: taken on zero / !zero.
    - blt/bge use SLT; bltu/bgeu use SLTU: taken on !zero / zero.
  - JAL (1101111): imm_src=J, branch=1, reg_write=1, wrt_back_src=PC4.
  - JALR (1100111): imm_src=I, ADD, alu_src=1, branch=1, reg_write=1, wrt_back_src=PC4.
  - LUI (0110111): imm_src=U, alu_src=1, PASS_B, reg_write=1, wrt_back_src=ALU.
- **ALU** (combinational).
  - B operand = alu_src ? immediate : rs2.
  - Operations: ADD/SUB wrap modulo 2^32. Shifts use B[4:0]. SLT is signed, SLTU unsigned; both return 0 or 1.
  - Undefined alu_ctrl gives result 0.
  - alu_zero = (alu_results == 0).
- **Data memory**: DEPTH x 32.
  - Word index = addr[9:2]; addr[1:0] is ignored. Only whole-word access.
  - Write is synchronous on the rising clk edge when the selected enable is 1.
  - Write port mux: init_done=0 → ext_w_addr/ext_w_dat/ext_w_enb; init_done=1 → alu_results[9:0]/rs2/mem_write.
  - Read is combinational: mem_rdata = mem_read ? mem[alu_results[9:2]] : 0. A read in the same cycle as a write to the same address returns the old data.
  - debug_data is always combinational from debug_addr.
  - Reset does not clear memory contents. Writes are suppressed while rst is low.

Decomposition:
- Shared package rv32i_pkg holds the opcodes, imm_src, wrt_back_src and alu_ctrl encodings.
- imm_src: I=000, S=001, B=010, U=011, J=100.
- wrt_back_src: MEM=00, ALU=01, PC4=10.
- alu_ctrl: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001, PASS_B=1010.
- Sub-modules: control_dec, alu32 and dmem32, instantiated by rv32i_exec_mem.

Test Plan:
- Init load: init_done=0, ext writes 0x00000001 to byte address 0x0 and 0x00000002 to 0x4 → debug_data reads 0x00000001 and 0x00000002.
- R-type SUB (opcode 0110011, func3 000, func7 0100000), rs1=1, rs2=2 → alu_ctrl=SUB, reg_write=1, alu_results=0xFFFFFFFF, alu_zero=0.
- Store: init_done=1, STORE, rs1=0, immediate=0xC, rs2=0xFFFFFFFF, one clk edge → debug_addr=0xC reads 0xFFFFFFFF; mem_write=0 on the next non-store instruction.
- Load: LOAD, rs1=0, immediate=4 → mem_read=1, mem_2_reg=1, mem_rdata=0x00000002, wrt_back_src=00.
- Branches:
  - beq with rs1=rs2=5 → alu_zero=1, branch=1.
  - bne with the same operands → branch=0.
  - blt with -1 < 1 → branch=1.
  - bltu with 0xFFFFFFFF vs 1 → branch=0.
- Reset: drive rst=0 mid-operation with a store pending → all control outputs 0, no memory write, previous memory contents intact.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i execute/memory slice: opcodes, immediate
// formats, write-back sources and ALU operations.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLL    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_exec_mem_if.sv
// External init/debug port of the data memory.
interface rv32i_exec_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] ext_w_addr;
  logic [DATA_WIDTH-1:0] ext_w_dat;
  logic                  ext_w_enb;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [DATA_WIDTH-1:0] debug_data;

  modport master (output init_done, ext_w_addr, ext_w_dat, ext_w_enb, debug_addr,
                  input  debug_data);
  modport slave  (input  init_done, ext_w_addr, ext_w_dat, ext_w_enb, debug_addr,
                  output debug_data);
endinterface

// File: rtl/alu32.sv
// Combinational ALU with immediate/register B-operand select.
module alu32
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  alu_src_i,
  input  logic [3:0]            alu_ctrl_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);
  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] b;
  logic [SH_W-1:0]       shamt;

  assign b     = alu_src_i ? imm_i : rs2_i;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD:    result_o = a_i + b;
      ALU_SUB:    result_o = a_i - b;
      ALU_AND:    result_o = a_i & b;
      ALU_OR:     result_o = a_i | b;
      ALU_XOR:    result_o = a_i ^ b;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $signed(a_i) >>> shamt;
      ALU_SLT:    result_o = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b)};
      ALU_SLTU:   result_o = {{(DATA_WIDTH-1){1'b0}}, a_i < b};
      ALU_PASS_B: result_o = b;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/control_dec.sv
// Main control decoder; all strobes are forced low while rst_n_i is low.
module control_dec
  import rv32i_pkg::*;
(
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       func7_5_i,
  input  logic       zero_i,
  output logic       branch_o,
  output imm_src_e   imm_src_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       alu_src_o,
  output logic       mem_2_reg_o,
  output alu_op_e    alu_ctrl_o,
  output wb_src_e    wb_src_o
);
  logic is_br;
  logic jump;
  logic take;

  always_comb begin
    imm_src_o   = IMM_I;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    reg_write_o = 1'b0;
    alu_src_o   = 1'b0;
    mem_2_reg_o = 1'b0;
    alu_ctrl_o  = ALU_ADD;
    wb_src_o    = WB_MEM;
    is_br       = 1'b0;
    jump        = 1'b0;
    if (rst_n_i) begin
      case (opcode_i)
        OP_R: begin
          reg_write_o = 1'b1;
          wb_src_o    = WB_ALU;
          alu_ctrl_o  = alu_op_from_f3(func3_i, func7_5_i);
        end
        OP_I: begin
          reg_write_o = 1'b1;
          alu_src_o   = 1'b1;
          wb_src_o    = WB_ALU;
          alu_ctrl_o  = alu_op_from_f3(func3_i, func7_5_i && (func3_i != 3'b000));
        end
        OP_LOAD: begin
          alu_src_o   = 1'b1;
          mem_read_o  = 1'b1;
          mem_2_reg_o = 1'b1;
          reg_write_o = 1'b1;
        end
        OP_STORE: begin
          alu_src_o   = 1'b1;
          imm_src_o   = IMM_S;
          mem_write_o = 1'b1;
        end
        OP_BRANCH: begin
          imm_src_o  = IMM_B;
          is_br      = 1'b1;
          alu_ctrl_o = !func3_i[2] ? ALU_SUB : (func3_i[1] ? ALU_SLTU : ALU_SLT);
        end
        OP_JAL: begin
          imm_src_o   = IMM_J;
          jump        = 1'b1;
          reg_write_o = 1'b1;
          wb_src_o    = WB_PC4;
        end
        OP_JALR: begin
          alu_src_o   = 1'b1;
          jump        = 1'b1;
          reg_write_o = 1'b1;
          wb_src_o    = WB_PC4;
        end
        OP_LUI: begin
          imm_src_o   = IMM_U;
          alu_src_o   = 1'b1;
          alu_ctrl_o  = ALU_PASS_B;
          reg_write_o = 1'b1;
          wb_src_o    = WB_ALU;
        end
        default: ;
      endcase
    end
  end

  // eq/ge/geu take on zero, ne/lt/ltu on non-zero
  always_comb begin
    take = 1'b0;
    case (func3_i)
      3'b000, 3'b101, 3'b111: take = zero_i;
      3'b001, 3'b100, 3'b110: take = !zero_i;
      default:                take = 1'b0;
    endcase
  end

  assign branch_o = rst_n_i && (jump || (is_br && take));
endmodule

// File: rtl/dmem32.sv
// Word-addressed data memory: one synchronous write port, two async read ports.
module dmem32 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic [IDX_W-1:0]      dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o    = re_i ? mem_q[raddr_i] : '0;
  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/rv32i_exec_mem.sv
// Execute/memory slice of the rv32i single-cycle core: decoder, ALU, data memory.
module rv32i_exec_mem
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] immediate,
  rv32i_exec_mem_if.slave       mem_if,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic                  mem_2_reg,
  output logic [3:0]            alu_ctrl,
  output logic [1:0]            wrt_back_src,
  output logic [DATA_WIDTH-1:0] alu_results,
  output logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int IDX_W = $clog2(DEPTH);

  imm_src_e              imm_src_w;
  alu_op_e               alu_ctrl_w;
  wb_src_e               wb_src_w;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_dat;
  logic                  w_en;
  logic                  unused_bits;

  assign imm_src      = imm_src_w;
  assign alu_ctrl     = alu_ctrl_w;
  assign wrt_back_src = wb_src_w;
  assign unused_bits  = ^{func7[6], func7[4:0], mem_if.ext_w_addr[1:0], mem_if.debug_addr[1:0]};

  control_dec u_ctrl (
    .rst_n_i     (rst),
    .opcode_i    (opcode),
    .func3_i     (func3),
    .func7_5_i   (func7[5]),
    .zero_i      (alu_zero),
    .branch_o    (branch),
    .imm_src_o   (imm_src_w),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .reg_write_o (reg_write),
    .alu_src_o   (alu_src),
    .mem_2_reg_o (mem_2_reg),
    .alu_ctrl_o  (alu_ctrl_w),
    .wb_src_o    (wb_src_w)
  );

  alu32 #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i        (rs1),
    .rs2_i      (rs2),
    .imm_i      (immediate),
    .alu_src_i  (alu_src),
    .alu_ctrl_i (alu_ctrl),
    .result_o   (alu_results),
    .zero_o     (alu_zero)
  );

  // Write port belongs to the external loader until init_done rises
  always_comb begin
    if (mem_if.init_done) begin
      w_idx = alu_results[IDX_W+1:2];
      w_dat = rs2;
      w_en  = mem_write;
    end else begin
      w_idx = mem_if.ext_w_addr[IDX_W+1:2];
      w_dat = mem_if.ext_w_dat;
      w_en  = mem_if.ext_w_enb;
    end
  end

  dmem32 #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_dmem (
    .clk_i      (clk),
    .we_i       (w_en && rst),
    .waddr_i    (w_idx),
    .wdata_i    (w_dat),
    .re_i       (mem_read),
    .raddr_i    (alu_results[IDX_W+1:2]),
    .rdata_o    (mem_rdata),
    .dbg_addr_i (mem_if.debug_addr[IDX_W+1:2]),
    .dbg_data_o (mem_if.debug_data)
  );
endmodule

// File: tb/tb_rv32i_exec_mem.sv
// Scoreboard bench for rv32i_exec_mem: expectations queued at drive time, compared after settling.
module tb_rv32i_exec_mem;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1, rs2, immediate;
  logic        branch, mem_read, mem_write, reg_write, alu_src, mem_2_reg, alu_zero;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;
  logic [31:0] alu_results, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_exec_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) mem_if ();

  rv32i_exec_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .rs1          (rs1),
    .rs2          (rs2),
    .immediate    (immediate),
    .mem_if       (mem_if),
    .branch       (branch),
    .imm_src      (imm_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .mem_2_reg    (mem_2_reg),
    .alu_ctrl     (alu_ctrl),
    .wrt_back_src (wrt_back_src),
    .alu_results  (alu_results),
    .alu_zero     (alu_zero),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_BR, S_IMM, S_MRD, S_MWR, S_RW, S_ASRC, S_M2R,
    S_ACTRL, S_WB, S_RES, S_ZERO, S_RDATA, S_DBG, S_CTRL
  } sel_e;

  sel_e        sel_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_BR:    return {31'b0, branch};
      S_IMM:   return {29'b0, imm_src};
      S_MRD:   return {31'b0, mem_read};
      S_MWR:   return {31'b0, mem_write};
      S_RW:    return {31'b0, reg_write};
      S_ASRC:  return {31'b0, alu_src};
      S_M2R:   return {31'b0, mem_2_reg};
      S_ACTRL: return {28'b0, alu_ctrl};
      S_WB:    return {30'b0, wrt_back_src};
      S_RES:   return alu_results;
      S_ZERO:  return {31'b0, alu_zero};
      S_RDATA: return mem_rdata;
      S_DBG:   return mem_if.debug_data;
      default: return {17'b0, branch, imm_src, mem_read, mem_write, reg_write,
                       alu_src, mem_2_reg, alu_ctrl, wrt_back_src};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sel_e s, input logic [31:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    string       t;
    sel_e        s;
    logic [31:0] e;
    #1;
    while (sel_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      check(t, observe(s), e);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    @(negedge clk);
    opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; immediate = imm;
  endtask

  task automatic ext_write(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_if.ext_w_addr = addr;
    mem_if.ext_w_dat  = data;
    mem_if.ext_w_enb  = 1'b1;
    @(posedge clk);
    #1;
    mem_if.ext_w_enb = 1'b0;
  endtask

  task automatic dbg_expect(input string tag, input logic [9:0] addr, input logic [31:0] v);
    @(negedge clk);
    mem_if.debug_addr = addr;
    expect_val(tag, S_DBG, v);
    drain();
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [31:0] r;
    pa[0] = 32'h8000_0010; pb[0] = 32'h0000_0003;
    pa[1] = 32'h0000_0007; pb[1] = 32'hFFFF_FFF9;

    rst = 1'b0;
    opcode = OP_JAL; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0; immediate = '0;
    mem_if.init_done = 1'b0; mem_if.ext_w_addr = '0; mem_if.ext_w_dat = '0;
    mem_if.ext_w_enb = 1'b0; mem_if.debug_addr = '0;

    @(negedge clk);
    expect_val("reset_ctrl", S_CTRL, 32'h0);
    expect_val("reset_branch", S_BR, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    ext_write(10'h000, 32'h0000_0001);
    ext_write(10'h004, 32'h0000_0002);
    ext_write(10'h00C, 32'h0000_0055);
    ext_write(10'h00B, 32'h0000_0077);
    ext_write(10'h3FC, 32'h0000_CAFE);
    dbg_expect("init_0", 10'h000, 32'h0000_0001);
    dbg_expect("init_4", 10'h004, 32'h0000_0002);
    dbg_expect("init_8_unaligned", 10'h008, 32'h0000_0077);
    dbg_expect("init_last", 10'h3FD, 32'h0000_CAFE);

    drive(OP_R, 3'b000, 7'h20, 32'd1, 32'd2, 32'd0);
    expect_val("sub_ctrl", S_ACTRL, 32'h1);
    expect_val("sub_rw", S_RW, 32'h1);
    expect_val("sub_res", S_RES, 32'hFFFF_FFFF);
    expect_val("sub_zero", S_ZERO, 32'h0);
    expect_val("sub_wb", S_WB, 32'h1);
    expect_val("sub_asrc", S_ASRC, 32'h0);
    expect_val("sub_rdata", S_RDATA, 32'h0);
    drain();

    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 8; f++) begin
        for (int alt = 0; alt < 2; alt++) begin
          drive(OP_R, 3'(f), alt ? 7'h20 : 7'h00, pa[p], pb[p], 32'h0);
          r = ref_alu(3'(f), alt[0], pa[p], pb[p]);
          expect_val($sformatf("r_f3%0d_alt%0d_p%0d", f, alt, p), S_RES, r);
          expect_val($sformatf("r_zero_f3%0d_alt%0d_p%0d", f, alt, p), S_ZERO, {31'b0, r == 0});
          drain();
        end
      end
    end

    drive(OP_I, 3'b000, 7'h20, 32'd5, 32'd100, 32'd3);
    expect_val("addi_res", S_RES, 32'd8);
    expect_val("addi_ctrl", S_ACTRL, 32'h0);
    expect_val("addi_asrc", S_ASRC, 32'h1);
    expect_val("addi_imm", S_IMM, 32'h0);
    expect_val("addi_rw", S_RW, 32'h1);
    drain();
    drive(OP_I, 3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_0404);
    expect_val("srai_res", S_RES, 32'hF800_0000);
    expect_val("srai_ctrl", S_ACTRL, 32'h7);
    drain();
    drive(OP_LUI, 3'b000, 7'h00, 32'h1234, 32'h99, 32'h1234_5000);
    expect_val("lui_res", S_RES, 32'h1234_5000);
    expect_val("lui_imm", S_IMM, 32'h3);
    expect_val("lui_ctrl", S_ACTRL, 32'hA);
    expect_val("lui_wb", S_WB, 32'h1);
    expect_val("lui_rw", S_RW, 32'h1);
    drain();

    mem_if.init_done  = 1'b1;
    mem_if.debug_addr = 10'h00C;
    drive(OP_STORE, 3'b010, 7'h00, 32'd0, 32'hFFFF_FFFF, 32'h0000_000C);
    mem_if.ext_w_addr = 10'h000;
    mem_if.ext_w_dat  = 32'h0000_0BAD;
    mem_if.ext_w_enb  = 1'b1;
    expect_val("st_mwr", S_MWR, 32'h1);
    expect_val("st_rw", S_RW, 32'h0);
    expect_val("st_imm", S_IMM, 32'h1);
    expect_val("st_ctrl", S_ACTRL, 32'h0);
    expect_val("st_res", S_RES, 32'h0000_000C);
    expect_val("st_old_data", S_DBG, 32'h0000_0055);
    drain();
    @(posedge clk);
    #1;
    mem_if.ext_w_enb = 1'b0;
    expect_val("st_written", S_DBG, 32'hFFFF_FFFF);
    drain();
    dbg_expect("ext_ignored", 10'h000, 32'h0000_0001);

    drive(OP_LOAD, 3'b010, 7'h00, 32'd0, 32'h1234_5678, 32'd4);
    expect_val("ld_mwr", S_MWR, 32'h0);
    expect_val("ld_mrd", S_MRD, 32'h1);
    expect_val("ld_m2r", S_M2R, 32'h1);
    expect_val("ld_rdata", S_RDATA, 32'h0000_0002);
    expect_val("ld_wb", S_WB, 32'h0);
    expect_val("ld_rw", S_RW, 32'h1);
    expect_val("ld_res", S_RES, 32'h4);
    drain();
    drive(OP_LOAD, 3'b010, 7'h00, 32'd0, 32'd0, 32'd6);
    expect_val("ld_unaligned", S_RDATA, 32'h0000_0002);
    drain();
    drive(OP_LOAD, 3'b010, 7'h00, 32'd8, 32'd0, 32'd4);
    expect_val("ld_stored", S_RDATA, 32'hFFFF_FFFF);
    drain();

    drive(OP_BRANCH, 3'b000, 7'h00, 32'd5, 32'd5, 32'h10);
    expect_val("beq_zero", S_ZERO, 32'h1);
    expect_val("beq_br", S_BR, 32'h1);
    expect_val("beq_ctrl", S_ACTRL, 32'h1);
    expect_val("beq_imm", S_IMM, 32'h2);
    expect_val("beq_asrc", S_ASRC, 32'h0);
    expect_val("beq_rw", S_RW, 32'h0);
    drain();
    drive(OP_BRANCH, 3'b001, 7'h00, 32'd5, 32'd5, 32'h10);
    expect_val("bne_br", S_BR, 32'h0);
    drain();
    drive(OP_BRANCH, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h10);
    expect_val("blt_res", S_RES, 32'h1);
    expect_val("blt_br", S_BR, 32'h1);
    drain();
    drive(OP_BRANCH, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h10);
    expect_val("bge_br", S_BR, 32'h0);
    drain();
    drive(OP_BRANCH, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h10);
    expect_val("bltu_res", S_RES, 32'h0);
    expect_val("bltu_br", S_BR, 32'h0);
    drain();
    drive(OP_BRANCH, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h10);
    expect_val("bgeu_br", S_BR, 32'h1);
    drain();

    drive(OP_JAL, 3'b000, 7'h00, 32'd0, 32'd0, 32'h20);
    expect_val("jal_br", S_BR, 32'h1);
    expect_val("jal_imm", S_IMM, 32'h4);
    expect_val("jal_rw", S_RW, 32'h1);
    expect_val("jal_wb", S_WB, 32'h2);
    drain();
    drive(OP_JALR, 3'b000, 7'h00, 32'h100, 32'd0, 32'h8);
    expect_val("jalr_br", S_BR, 32'h1);
    expect_val("jalr_imm", S_IMM, 32'h0);
    expect_val("jalr_asrc", S_ASRC, 32'h1);
    expect_val("jalr_res", S_RES, 32'h108);
    expect_val("jalr_wb", S_WB, 32'h2);
    drain();
    drive(7'h7F, 3'b000, 7'h00, 32'd1, 32'd1, 32'd1);
    expect_val("unknown_ctrl", S_CTRL, 32'h0);
    drain();

    drive(OP_STORE, 3'b010, 7'h00, 32'd0, 32'h0000_DEAD, 32'd0);
    rst = 1'b0;
    expect_val("rst_mid_ctrl", S_CTRL, 32'h0);
    expect_val("rst_mid_br", S_BR, 32'h0);
    drain();
    @(posedge clk);
    #1;
    @(negedge clk);
    opcode = 7'h7F;
    rst = 1'b1;
    dbg_expect("rst_no_write", 10'h000, 32'h0000_0001);
    dbg_expect("rst_kept", 10'h00C, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
